ysyx_22050550_mul_ctrl: RTL and testbench

YSYX_22050550_MUL_CTRL -- requirements
Module: ysyx_22050550_mul_ctrl

---
 rtl/ysyx_22050550_mul_ctrl_pkg.sv | 70 +++++++
 rtl/ysyx_22050550_mul_cache.sv | 64 ++++++
 rtl/ysyx_22050550_mul_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ysyx_22050550_mul_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050550_mul_ctrl_pkg.sv
// Shared definitions for the multiply controller: op encodings, FSM state
// encodings, multiplier signedness constants, the operand-cache entry layout
// and small decode helpers used by the controller and its cache.
package ysyx_22050550_mul_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_MULW   = 3'd4
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } mul_state_e;

    localparam logic [1:0] SGN_SS = 2'b11;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_UU = 2'b00;

    typedef struct packed {
        logic        valid;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [1:0]  sgn;
        logic [63:0] res_h;
        logic [63:0] res_l;
    } cache_entry_t;

    // Encodings 5..7 are aliases of MUL.
    function automatic mul_op_e norm_op(input logic [2:0] op);
        mul_op_e r;
        case (op)
            3'd1:    r = OP_MULH;
            3'd2:    r = OP_MULHSU;
            3'd3:    r = OP_MULHU;
            3'd4:    r = OP_MULW;
            default: r = OP_MUL;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] op_signed(input mul_op_e op);
        logic [1:0] r;
        case (op)
            OP_MULHSU: r = SGN_SU;
            OP_MULHU:  r = SGN_UU;
            default:   r = SGN_SS;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] sel_result(input mul_op_e op,
                                               input logic [63:0] res_h,
                                               input logic [63:0] res_l);
        logic [63:0] r;
        case (op)
            OP_MUL:  r = res_l;
            OP_MULW: r = {{32{res_l[31]}}, res_l[31:0]};
            default: r = res_h;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22050550_mul_cache.sv
// Single-entry last-result cache for the multiply controller.
// Ports:
//   clock, reset          - clock and async active-low reset (clears valid)
//   lookup_*              - operands/signedness/op class of the incoming request
//   hit, hit_h, hit_l     - hit flag and stored 128-bit product halves
//   wr_*                  - write port, loaded from a completed unflushed op
module ysyx_22050550_mul_cache
    import ysyx_22050550_mul_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] lookup_rs1,
    input  logic [63:0] lookup_rs2,
    input  logic [1:0]  lookup_signed,
    input  logic        lookup_is_mul,
    input  logic        lookup_is_mulw,
    output logic        hit,
    output logic [63:0] hit_h,
    output logic [63:0] hit_l,
    input  logic        wr_en,
    input  logic [63:0] wr_rs1,
    input  logic [63:0] wr_rs2,
    input  logic [1:0]  wr_signed,
    input  logic [63:0] wr_h,
    input  logic [63:0] wr_l
);

    cache_entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (CACHE_EN && wr_en) begin
            entry_d.valid = 1'b1;
            entry_d.rs1   = wr_rs1;
            entry_d.rs2   = wr_rs2;
            entry_d.sgn   = wr_signed;
            entry_d.res_h = wr_h;
            entry_d.res_l = wr_l;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    // The low product half does not depend on signedness, so MUL may reuse an
    // entry produced by any high-half op. MULW results are never stored, so
    // the entry is always from a non-MULW op.
    always_comb begin
        hit = CACHE_EN && entry_q.valid && !lookup_is_mulw &&
              (entry_q.rs1 == lookup_rs1) && (entry_q.rs2 == lookup_rs2) &&
              (lookup_is_mul || (entry_q.sgn == lookup_signed));
    end

    assign hit_h = entry_q.res_h;
    assign hit_l = entry_q.res_l;

endmodule

// File: rtl/ysyx_22050550_mul_ctrl.sv
// Multiply controller: accepts MUL-family ops from the EXU, issues at most one
// op to an external multiplier, selects the result and hands it to writeback.
// A last-result cache short-circuits repeated operand pairs.
// Ports:
//   clock, reset                  - clock, async active-low reset
//   io_Exu_*                      - request handshake, op, operands, flush
//   io_Wb_*                       - result handshake to writeback
//   io_Mul_*                      - issue/result interface to the multiplier
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request; hit -> DONE, miss -> ISSUE
// ISSUE    | MulValid driven, waiting for MulReady
// WAIT     | op accepted by multiplier, waiting for OutValid
// DONE     | result presented on Wb until OutReady
// DRAIN    | flushed op still in the multiplier; discard its result
module ysyx_22050550_mul_ctrl
    import ysyx_22050550_mul_ctrl_pkg::*;
#(
    parameter int CACHE_EN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_Exu_Valid,
    output logic        io_Exu_Ready,
    input  logic [2:0]  io_Exu_Op,
    input  logic [63:0] io_Exu_Rs1,
    input  logic [63:0] io_Exu_Rs2,
    input  logic        io_Exu_Flush,
    output logic        io_Wb_OutValid,
    input  logic        io_Wb_OutReady,
    output logic [63:0] io_Wb_Result,
    output logic        io_Mul_MulValid,
    output logic        io_Mul_Mulw,
    output logic [1:0]  io_Mul_MulSigned,
    output logic [63:0] io_Mul_Multiplicand,
    output logic [63:0] io_Mul_Multiplier,
    input  logic        io_Mul_MulReady,
    input  logic        io_Mul_OutValid,
    input  logic [63:0] io_Mul_ResultH,
    input  logic [63:0] io_Mul_ResultL
);

    mul_state_e  state_q, state_d;
    mul_op_e     op_q, op_d;
    logic [63:0] rs1_q, rs1_d;
    logic [63:0] rs2_q, rs2_d;
    logic [63:0] result_q, result_d;

    mul_op_e     in_op;
    logic        accept;
    logic        cache_hit;
    logic [63:0] cache_h, cache_l;
    logic        cache_wr;

    assign in_op  = norm_op(io_Exu_Op);
    assign accept = io_Exu_Valid && (state_q == ST_IDLE) && !io_Exu_Flush;

    assign cache_wr = (state_q == ST_WAIT) && io_Mul_OutValid && !io_Exu_Flush &&
                      (op_q != OP_MULW);

    ysyx_22050550_mul_cache #(
        .CACHE_EN (CACHE_EN != 0)
    ) u_cache (
        .clock          (clock),
        .reset          (reset),
        .lookup_rs1     (io_Exu_Rs1),
        .lookup_rs2     (io_Exu_Rs2),
        .lookup_signed  (op_signed(in_op)),
        .lookup_is_mul  (in_op == OP_MUL),
        .lookup_is_mulw (in_op == OP_MULW),
        .hit            (cache_hit),
        .hit_h          (cache_h),
        .hit_l          (cache_l),
        .wr_en          (cache_wr),
        .wr_rs1         (rs1_q),
        .wr_rs2         (rs2_q),
        .wr_signed      (op_signed(op_q)),
        .wr_h           (io_Mul_ResultH),
        .wr_l           (io_Mul_ResultL)
    );

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        rs1_d           = rs1_q;
        rs2_d           = rs2_q;
        result_d        = result_q;
        io_Exu_Ready    = 1'b0;
        io_Mul_MulValid = 1'b0;
        io_Wb_OutValid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                io_Exu_Ready = 1'b1;
                if (accept) begin
                    op_d  = in_op;
                    rs1_d = io_Exu_Rs1;
                    rs2_d = io_Exu_Rs2;
                    if (cache_hit) begin
                        result_d = sel_result(in_op, cache_h, cache_l);
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                io_Mul_MulValid = 1'b1;
                if (io_Exu_Flush) begin
                    // Once the multiplier has taken the op its result must be drained.
                    state_d = io_Mul_MulReady ? ST_DRAIN : ST_IDLE;
                end else if (io_Mul_MulReady) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (io_Mul_OutValid) begin
                    if (io_Exu_Flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        result_d = sel_result(op_q, io_Mul_ResultH, io_Mul_ResultL);
                        state_d  = ST_DONE;
                    end
                end else if (io_Exu_Flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                io_Wb_OutValid = 1'b1;
                if (io_Exu_Flush || io_Wb_OutReady) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (io_Mul_OutValid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            result_q <= result_d;
        end
    end

    // Multiplier-side operands and flags are qualified by MulValid so they
    // read as zero outside ISSUE, including during reset.
    assign io_Mul_MulSigned    = io_Mul_MulValid ? op_signed(op_q) : 2'b00;
    assign io_Mul_Mulw         = io_Mul_MulValid && (op_q == OP_MULW);
    assign io_Mul_Multiplicand = io_Mul_MulValid ? rs1_q : 64'd0;
    assign io_Mul_Multiplier   = io_Mul_MulValid ? rs2_q : 64'd0;
    assign io_Wb_Result        = result_q;

endmodule

// File: tb/tb_ysyx_22050550_mul_ctrl.sv
// Directed bench for the multiply controller. A behavioural multiplier with
// programmable latency answers issues; expected writeback results are
// hand-computed constants pushed into a queue and checked by a monitor.
module tb_ysyx_22050550_mul_ctrl;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] MULW   = 3'd4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_Exu_Valid = 1'b0;
    logic        io_Exu_Ready;
    logic [2:0]  io_Exu_Op = 3'd0;
    logic [63:0] io_Exu_Rs1 = 64'd0;
    logic [63:0] io_Exu_Rs2 = 64'd0;
    logic        io_Exu_Flush = 1'b0;
    logic        io_Wb_OutValid;
    logic        io_Wb_OutReady = 1'b1;
    logic [63:0] io_Wb_Result;
    logic        io_Mul_MulValid;
    logic        io_Mul_Mulw;
    logic [1:0]  io_Mul_MulSigned;
    logic [63:0] io_Mul_Multiplicand;
    logic [63:0] io_Mul_Multiplier;
    logic        io_Mul_MulReady = 1'b1;
    logic        io_Mul_OutValid = 1'b0;
    logic [63:0] io_Mul_ResultH = 64'd0;
    logic [63:0] io_Mul_ResultL = 64'd0;

    ysyx_22050550_mul_ctrl #(.CACHE_EN(1)) dut (
        .clock               (clock),
        .reset               (reset),
        .io_Exu_Valid        (io_Exu_Valid),
        .io_Exu_Ready        (io_Exu_Ready),
        .io_Exu_Op           (io_Exu_Op),
        .io_Exu_Rs1          (io_Exu_Rs1),
        .io_Exu_Rs2          (io_Exu_Rs2),
        .io_Exu_Flush        (io_Exu_Flush),
        .io_Wb_OutValid      (io_Wb_OutValid),
        .io_Wb_OutReady      (io_Wb_OutReady),
        .io_Wb_Result        (io_Wb_Result),
        .io_Mul_MulValid     (io_Mul_MulValid),
        .io_Mul_Mulw         (io_Mul_Mulw),
        .io_Mul_MulSigned    (io_Mul_MulSigned),
        .io_Mul_Multiplicand (io_Mul_Multiplicand),
        .io_Mul_Multiplier   (io_Mul_Multiplier),
        .io_Mul_MulReady     (io_Mul_MulReady),
        .io_Mul_OutValid     (io_Mul_OutValid),
        .io_Mul_ResultH      (io_Mul_ResultH),
        .io_Mul_ResultL      (io_Mul_ResultL)
    );

    always #5 clock = ~clock;

    // ---------------- multiplier model ----------------
    int           mul_lat   = 0;
    int           issue_cnt = 0;
    int           mul_cnt   = 0;
    bit           mul_pend  = 1'b0;
    logic [127:0] prod      = '0;

    function automatic logic [127:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                               input logic [1:0] sgn);
        logic [127:0] ea, eb;
        ea = sgn[1] ? {{64{a[63]}}, a} : {64'd0, a};
        eb = sgn[0] ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    always begin
        @(negedge clock);
        if (io_Mul_MulValid && io_Mul_MulReady) begin
            issue_cnt = issue_cnt + 1;
            prod      = mul_model(io_Mul_Multiplicand, io_Mul_Multiplier, io_Mul_MulSigned);
            mul_cnt   = mul_lat;
            mul_pend  = 1'b1;
        end
        @(posedge clock);
        #1;
        io_Mul_OutValid = 1'b0;
        if (mul_pend) begin
            if (mul_cnt == 0) begin
                io_Mul_OutValid = 1'b1;
                io_Mul_ResultH  = prod[127:64];
                io_Mul_ResultL  = prod[63:0];
                mul_pend        = 1'b0;
            end else begin
                mul_cnt = mul_cnt - 1;
            end
        end
    end

    // ---------------- scoreboard and checking ----------------
    logic [63:0] sb_q[$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec  = n_vec + 1;
        n_fail = n_fail + 1;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic monitor_loop();
        logic [63:0] exp;
        forever begin
            @(negedge clock);
            if (reset && io_Wb_OutValid && io_Wb_OutReady) begin
                if (sb_q.size() == 0) begin
                    n_vec  = n_vec + 1;
                    n_fail = n_fail + 1;
                    $display("FAIL wb_unexpected: got result %h, required no output", io_Wb_Result);
                end else begin
                    exp = sb_q.pop_front();
                    check("wb_result", io_Wb_Result, exp);
                end
            end
        end
    endtask

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        io_Exu_Valid = 1'b1;
        io_Exu_Op    = op;
        io_Exu_Rs1   = a;
        io_Exu_Rs2   = b;
        while (1) begin
            @(negedge clock);
            if (io_Exu_Ready) break;
            n++;
            if (n > 200) begin
                fail_now("accept");
                break;
            end
        end
        @(posedge clock);
        #1;
        io_Exu_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (1) begin
            @(negedge clock);
            if (sb_q.size() == 0 && io_Exu_Ready) break;
            n++;
            if (n > 200) begin
                fail_now(name);
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_wb_valid(input string name);
        int n;
        n = 0;
        while (1) begin
            @(negedge clock);
            if (io_Wb_OutValid) break;
            n++;
            if (n > 200) begin
                fail_now(name);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_exu_ready"},    {63'd0, io_Exu_Ready},        64'd1);
        check({tag, "_wb_valid"},     {63'd0, io_Wb_OutValid},      64'd0);
        check({tag, "_wb_result"},    io_Wb_Result,                 64'd0);
        check({tag, "_mul_valid"},    {63'd0, io_Mul_MulValid},     64'd0);
        check({tag, "_mul_signed"},   {62'd0, io_Mul_MulSigned},    64'd0);
        check({tag, "_mulw"},         {63'd0, io_Mul_Mulw},         64'd0);
        check({tag, "_multiplicand"}, io_Mul_Multiplicand,          64'd0);
        check({tag, "_multiplier"},   io_Mul_Multiplier,            64'd0);
    endtask

    initial begin
        #20000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  base;
        bit  saw_ready;
        fork
            monitor_loop();
        join_none

        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // MUL 3 x 5 miss, then MULHU 2^63 x 4
        base = issue_cnt;
        sb_q.push_back(64'd15);
        send(MUL, 64'd3, 64'd5);
        check("mul_issue_flags", {62'd0, io_Mul_MulSigned}, 64'd3);
        wait_idle("mul_3x5");
        check("mul_3x5_issues", issue_cnt - base, 1);
        sb_q.push_back(64'd2);
        send(MULHU, 64'h8000_0000_0000_0000, 64'd4);
        check("mulhu_issue_flags", {62'd0, io_Mul_MulSigned}, 64'd0);
        wait_idle("mulhu");
        check("mulhu_issues", issue_cnt - base, 2);

        // MULH -1 x -1 miss, then MUL same operands hits the cache
        base = issue_cnt;
        sb_q.push_back(64'd0);
        send(MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle("mulh");
        check("mulh_issues", issue_cnt - base, 1);
        sb_q.push_back(64'd1);
        send(MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("hit_outvalid_next_cycle", {63'd0, io_Wb_OutValid}, 64'd1);
        check("hit_no_mulvalid", {63'd0, io_Mul_MulValid}, 64'd0);
        wait_idle("mul_hit");
        check("hit_issues", issue_cnt - base, 1);

        // MULW twice: both must issue
        base = issue_cnt;
        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        send(MULW, 64'h7FFF_FFFF, 64'd2);
        check("mulw_flag", {63'd0, io_Mul_Mulw}, 64'd1);
        wait_idle("mulw1");
        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        send(MULW, 64'h7FFF_FFFF, 64'd2);
        wait_idle("mulw2");
        check("mulw_repeat_issues", issue_cnt - base, 2);

        // Flush 3 cycles after issue -> DRAIN
        mul_lat = 5;
        base = issue_cnt;
        send(MUL, 64'd6, 64'd7);
        @(posedge clock); #1;
        @(posedge clock); #1;
        io_Exu_Flush = 1'b1;
        @(posedge clock); #1;
        io_Exu_Flush = 1'b0;
        check("drain_ready_low", {63'd0, io_Exu_Ready}, 64'd0);
        saw_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (io_Wb_OutValid) check("drain_no_outvalid", {63'd0, io_Wb_OutValid}, 64'd0);
            if (io_Exu_Ready) begin
                saw_ready = 1'b1;
                break;
            end
        end
        if (!saw_ready) fail_now("drain_exit");
        @(posedge clock); #1;
        check("flush_issues", issue_cnt - base, 1);
        sb_q.push_back(64'd42);
        send(MUL, 64'd6, 64'd7);
        wait_idle("after_drain");
        check("after_drain_issues", issue_cnt - base, 2);
        mul_lat = 0;

        // OutReady held low in DONE
        io_Wb_OutReady = 1'b0;
        sb_q.push_back(64'd81);
        send(MUL, 64'd9, 64'd9);
        wait_wb_valid("done_hold");
        for (int i = 0; i < 5; i++) begin
            check("done_hold_result", io_Wb_Result, 64'd81);
            check("done_hold_ready", {63'd0, io_Exu_Ready}, 64'd0);
            check("done_hold_valid", {63'd0, io_Wb_OutValid}, 64'd1);
            @(negedge clock);
        end
        @(posedge clock); #1;
        io_Wb_OutReady = 1'b1;
        wait_idle("done_release");

        // Flush in DONE drops the result
        io_Wb_OutReady = 1'b0;
        send(MUL, 64'd10, 64'd10);
        wait_wb_valid("done_flush");
        @(posedge clock); #1;
        io_Exu_Flush = 1'b1;
        @(posedge clock); #1;
        io_Exu_Flush = 1'b0;
        check("done_flush_outvalid", {63'd0, io_Wb_OutValid}, 64'd0);
        check("done_flush_ready", {63'd0, io_Exu_Ready}, 64'd1);
        io_Wb_OutReady = 1'b1;

        // Reset asserted in WAIT
        mul_lat = 4;
        send(MUL, 64'd11, 64'd11);
        @(posedge clock); #1;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(posedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (io_Wb_OutValid || !io_Exu_Ready)
                check("stale_ignored", {62'd0, io_Wb_OutValid, !io_Exu_Ready}, 64'd0);
        end
        check("stale_delivered", {63'd0, mul_pend}, 64'd0);
        @(posedge clock); #1;
        mul_lat = 0;
        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        send(MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
        check("mulhsu_flags", {62'd0, io_Mul_MulSigned}, 64'd2);
        wait_idle("mulhsu");
        // Cache was cleared by reset: this must issue again.
        base = issue_cnt;
        sb_q.push_back(64'd1);
        send(MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle("post_reset_miss");
        check("post_reset_miss_issues", issue_cnt - base, 1);

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
